// File: rtl/mem_sequencer.sv
// Multicycle sequencer and single-port memory arbiter for the rv32i core:
// serialises fetch, load/store and debug accesses and strobes core_en once per instruction.
module mem_sequencer #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  input  logic [31:0] ALUResult,
  input  logic [31:0] rd2,
  input  logic        MemWrite,
  output logic [31:0] instruccion,
  output logic [31:0] ReadData,
  output logic        core_en,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  input  logic        dbg_req,
  input  logic        dbg_we,
  input  logic [31:0] dbg_addr,
  input  logic [31:0] dbg_wdata,
  output logic        dbg_gnt,
  output logic        dbg_done,
  output logic [31:0] dbg_rdata,
  output logic        bus_err,
  output logic [31:0] instret
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {FETCH, EXEC, DATA, COMMIT, DBG, HALT} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] wait_cnt;
  logic          is_load, is_store, timed_out;

  assign is_load  = (instruccion[6:0] == 7'b0000011);
  assign is_store = (instruccion[6:0] == 7'b0100011);

  always_comb begin
    state_nx  = state;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    core_en   = 1'b0;
    dbg_gnt   = 1'b0;
    timed_out = 1'b0;
    case (state)
      FETCH: begin
        mem_req  = 1'b1;
        mem_addr = pc;
        if (mem_ready) state_nx = EXEC;
      end
      EXEC: begin
        if (is_load || is_store) begin
          state_nx = DATA;
        end else begin
          core_en  = 1'b1;
          state_nx = dbg_req ? DBG : FETCH;
        end
      end
      DATA: begin
        mem_req   = 1'b1;
        mem_addr  = ALUResult;
        mem_we    = MemWrite;
        mem_wdata = rd2;
        if (mem_ready) state_nx = COMMIT;
      end
      COMMIT: begin
        core_en  = 1'b1;
        state_nx = dbg_req ? DBG : FETCH;
      end
      DBG: begin
        dbg_gnt   = 1'b1;
        mem_req   = 1'b1;
        mem_addr  = dbg_addr;
        mem_we    = dbg_we;
        mem_wdata = dbg_wdata;
        if (mem_ready) state_nx = FETCH;
      end
      default: state_nx = HALT;
    endcase
    if (mem_req && !mem_ready && wait_cnt == CW'(TIMEOUT - 1)) begin
      timed_out = 1'b1;
      state_nx  = HALT;
    end
    // State already sits in FETCH during reset; keep the bus and strobes quiet until release.
    if (reset) begin
      mem_req = 1'b0;
      mem_we  = 1'b0;
      core_en = 1'b0;
      dbg_gnt = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= FETCH;
      instruccion <= 32'h0000_0013;
      ReadData    <= '0;
      dbg_rdata   <= '0;
      dbg_done    <= 1'b0;
      bus_err     <= 1'b0;
      instret     <= '0;
      wait_cnt    <= '0;
    end else begin
      state    <= state_nx;
      dbg_done <= 1'b0;
      if (mem_req && !mem_ready) wait_cnt <= wait_cnt + 1'b1;
      else                       wait_cnt <= '0;
      if (timed_out) bus_err <= 1'b1;
      if (core_en) instret <= instret + 32'd1;
      if (state == FETCH && mem_ready) instruccion <= mem_rdata;
      if (state == DATA && mem_ready && is_load) ReadData <= mem_rdata;
      if (state == DBG && mem_ready) begin
        dbg_done <= 1'b1;
        if (!dbg_we) dbg_rdata <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_sequencer.sv
// Directed cycle-by-cycle bench for mem_sequencer: inputs change at the falling edge,
// outputs are checked 1 ns later, expected values are hand-computed.
module tb_mem_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc, ALUResult, rd2;
  logic        MemWrite;
  logic [31:0] instruccion, ReadData;
  logic        core_en, mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ready;
  logic        dbg_req, dbg_we;
  logic [31:0] dbg_addr, dbg_wdata;
  logic        dbg_gnt, dbg_done;
  logic [31:0] dbg_rdata;
  logic        bus_err;
  logic [31:0] instret;

  int unsigned total = 0;
  int unsigned bad   = 0;

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] ADDI = 32'h0030_0413;
  localparam logic [31:0] SW   = 32'h0080_2023;
  localparam logic [31:0] LW   = 32'h0000_2483;

  always #5 clk = ~clk;

  mem_sequencer #(.TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .pc(pc), .ALUResult(ALUResult), .rd2(rd2),
    .MemWrite(MemWrite), .instruccion(instruccion), .ReadData(ReadData),
    .core_en(core_en), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt), .dbg_done(dbg_done), .dbg_rdata(dbg_rdata),
    .bus_err(bus_err), .instret(instret)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; pc = '0; ALUResult = '0; rd2 = '0; MemWrite = 1'b0;
    mem_rdata = '0; mem_ready = 1'b0;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;

    // reset values
    cyc(); cyc(); #1;
    check("rst_req", 32'(mem_req), 32'd0);
    check("rst_we", 32'(mem_we), 32'd0);
    check("rst_core_en", 32'(core_en), 32'd0);
    check("rst_instr", instruccion, NOP);
    check("rst_rdata", ReadData, 32'd0);
    check("rst_instret", instret, 32'd0);
    check("rst_bus_err", 32'(bus_err), 32'd0);
    check("rst_gnt", 32'(dbg_gnt), 32'd0);
    check("rst_done", 32'(dbg_done), 32'd0);
    check("rst_dbg_rdata", dbg_rdata, 32'd0);

    // ADDI, zero wait: FETCH then EXEC
    cyc(); reset = 1'b0; pc = 32'h0; mem_ready = 1'b1; mem_rdata = ADDI; #1;
    check("addi_f_req", 32'(mem_req), 32'd1);
    check("addi_f_addr", mem_addr, 32'h0);
    check("addi_f_we", 32'(mem_we), 32'd0);
    check("addi_f_cen", 32'(core_en), 32'd0);
    cyc(); mem_ready = 1'b0; #1;
    check("addi_e_cen", 32'(core_en), 32'd1);
    check("addi_e_req", 32'(mem_req), 32'd0);
    check("addi_e_instr", instruccion, ADDI);

    // SW x8,0(x0) with x8=3
    cyc(); pc = 32'h4; mem_ready = 1'b1; mem_rdata = SW; #1;
    check("addi_instret", instret, 32'd1);
    check("sw_f_cen", 32'(core_en), 32'd0);
    check("sw_f_addr", mem_addr, 32'h4);
    cyc(); ALUResult = 32'h0; rd2 = 32'd3; MemWrite = 1'b1; #1;
    check("sw_e_cen", 32'(core_en), 32'd0);
    check("sw_e_req", 32'(mem_req), 32'd0);
    cyc(); mem_ready = 1'b1; #1;
    check("sw_d_req", 32'(mem_req), 32'd1);
    check("sw_d_we", 32'(mem_we), 32'd1);
    check("sw_d_addr", mem_addr, 32'h0);
    check("sw_d_wdata", mem_wdata, 32'd3);
    check("sw_d_cen", 32'(core_en), 32'd0);
    cyc(); #1;
    check("sw_c_cen", 32'(core_en), 32'd1);
    check("sw_c_req", 32'(mem_req), 32'd0);

    // LW x9,0x20 with two wait states in DATA
    cyc(); pc = 32'h8; mem_ready = 1'b1; mem_rdata = LW; MemWrite = 1'b0; ALUResult = 32'h20; #1;
    check("sw_instret", instret, 32'd2);
    cyc(); #1;
    check("lw_e_cen", 32'(core_en), 32'd0);
    cyc(); mem_ready = 1'b0; mem_rdata = 32'h1111_1111; #1;
    check("lw_w1_addr", mem_addr, 32'h20);
    check("lw_w1_we", 32'(mem_we), 32'd0);
    cyc(); #1;
    check("lw_w2_addr", mem_addr, 32'h20);
    check("lw_w2_req", 32'(mem_req), 32'd1);
    check("lw_w2_cen", 32'(core_en), 32'd0);
    cyc(); mem_ready = 1'b1; mem_rdata = 32'hDEAD_BEEF; #1;
    check("lw_w3_addr", mem_addr, 32'h20);
    cyc(); mem_ready = 1'b0; #1;
    check("lw_c_cen", 32'(core_en), 32'd1);
    check("lw_c_rdata", ReadData, 32'hDEAD_BEEF);

    // debug read requested while a fetch is stalled
    cyc(); pc = 32'hC; dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h40; mem_ready = 1'b0; #1;
    check("lw_instret", instret, 32'd3);
    check("dbg_f_gnt", 32'(dbg_gnt), 32'd0);
    check("dbg_f_addr", mem_addr, 32'hC);
    cyc(); mem_ready = 1'b1; mem_rdata = ADDI; #1;
    check("dbg_f2_addr", mem_addr, 32'hC);
    cyc(); mem_ready = 1'b0; #1;
    check("dbg_e_cen", 32'(core_en), 32'd1);
    check("dbg_e_gnt", 32'(dbg_gnt), 32'd0);
    cyc(); mem_ready = 1'b1; mem_rdata = 32'hCAFE_F00D; #1;
    check("dbg_g_gnt", 32'(dbg_gnt), 32'd1);
    check("dbg_g_addr", mem_addr, 32'h40);
    check("dbg_g_req", 32'(mem_req), 32'd1);
    check("dbg_g_cen", 32'(core_en), 32'd0);
    check("dbg_g_done", 32'(dbg_done), 32'd0);
    cyc(); dbg_req = 1'b0; pc = 32'h10; mem_ready = 1'b1; mem_rdata = ADDI; #1;
    check("dbg_done", 32'(dbg_done), 32'd1);
    check("dbg_rdata", dbg_rdata, 32'hCAFE_F00D);
    check("dbg_n_gnt", 32'(dbg_gnt), 32'd0);
    check("dbg_n_fetch_addr", mem_addr, 32'h10);
    check("dbg_instret", instret, 32'd4);
    cyc(); #1;
    check("dbg_done_clr", 32'(dbg_done), 32'd0);
    check("dbg_n_cen", 32'(core_en), 32'd1);

    // reset while a load waits in DATA
    cyc(); mem_ready = 1'b1; mem_rdata = LW; ALUResult = 32'h20; #1;
    check("pre_rst_instret", instret, 32'd5);
    cyc(); #1;
    cyc(); mem_ready = 1'b0; #1;
    check("rd_d_req", 32'(mem_req), 32'd1);
    reset = 1'b1; #1;
    check("rd_req", 32'(mem_req), 32'd0);
    check("rd_instr", instruccion, NOP);
    check("rd_instret", instret, 32'd0);
    check("rd_rdata", ReadData, 32'd0);
    check("rd_dbg_rdata", dbg_rdata, 32'd0);
    cyc(); reset = 1'b0; pc = 32'h0; mem_ready = 1'b1; mem_rdata = ADDI; #1;
    check("rd_f_req", 32'(mem_req), 32'd1);
    check("rd_f_addr", mem_addr, 32'h0);
    cyc(); #1;
    check("rd_e_cen", 32'(core_en), 32'd1);
    check("rd_e_instret", instret, 32'd0);

    // timeout: fetch never completes
    cyc(); pc = 32'h4; mem_ready = 1'b0; #1;
    check("rd_instret", instret, 32'd1);
    for (int i = 2; i <= 16; i++) begin
      cyc(); #1;
      check($sformatf("to_wait%0d_err", i), 32'(bus_err), 32'd0);
      check($sformatf("to_wait%0d_req", i), 32'(mem_req), 32'd1);
    end
    cyc(); #1;
    check("to_bus_err", 32'(bus_err), 32'd1);
    check("to_req", 32'(mem_req), 32'd0);
    cyc(); mem_ready = 1'b1; #1;
    check("to_halt_req", 32'(mem_req), 32'd0);
    check("to_halt_cen", 32'(core_en), 32'd0);
    cyc(); #1;
    check("to_halt_err", 32'(bus_err), 32'd1);
    check("to_halt_instret", instret, 32'd1);
    reset = 1'b1; #1;
    check("to_rst_err", 32'(bus_err), 32'd0);
    cyc(); reset = 1'b0; #1;
    check("to_rst_req", 32'(mem_req), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_sequencer.md
# mem_sequencer

Multicycle sequencer and memory arbiter for the `rv32i` core. It shares one single-ported unified memory between core instruction fetch, core data access (LW/SW) and a debug/loader port. It holds the core still between phases by withholding `core_en`, which gates every core state update (pc, register file). It also drives the core's `instruccion` and `ReadData` inputs from internal registers.

## Interface
- `TIMEOUT`, 16: maximum cycles one memory request may wait for `mem_ready` before a bus error is flagged.
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `pc`  in  32  core program counter.
- `ALUResult`  in  32  core ALU output; the data address during LW/SW.
- `rd2`  in  32  core store data.
- `MemWrite`  in  1  core store indication.
- `instruccion`  out  32  latched instruction presented to the core.
- `ReadData`  out  32  latched load data presented to the core.
- `core_en`  out  1  one-cycle commit strobe; core state updates only when high.
- `mem_req`, `mem_we`  out  1  memory request and write enable.
- `mem_addr`, `mem_wdata`  out  32  memory address and write data.
- `mem_rdata`  in  32  memory read data, valid when `mem_ready` is high.
- `mem_ready`  in  1  memory completion; meaningful only while `mem_req` is high.
- `dbg_req`, `dbg_we`  in  1  debug request and write enable; held until `dbg_done`.
- `dbg_addr`, `dbg_wdata`  in  32  debug address and write data.
- `dbg_gnt`  out  1  high while the debug transaction owns memory.
- `dbg_done`  out  1  one-cycle pulse when the debug transaction completes.
- `dbg_rdata`  out  32  debug read data, latched on completion.
- `bus_err`  out  1  sticky timeout flag.
- `instret`  out  32  retired-instruction counter.

## Operation
- States: FETCH, EXEC, DATA, COMMIT, DBG, HALT.
- **FETCH:** `mem_req`=1, `mem_we`=0, `mem_addr`=`pc`. When `mem_ready` is high, latch `mem_rdata` into `instruccion` and go to EXEC.
- **EXEC:** `instruccion[6:0]` is decoded.
  - 0000011 (load) or 0100011 (store): go to DATA, `core_en`=0.
  - Anything else: `core_en`=1, then go to DBG if `dbg_req` is high, otherwise FETCH.
- **DATA:** `mem_req`=1, `mem_addr`=`ALUResult`, `mem_we`=`MemWrite`, `mem_wdata`=`rd2`. When `mem_ready` is high:
  - A load latches `mem_rdata` into `ReadData`.
  - Both loads and stores go to COMMIT.
- **COMMIT:** `core_en`=1; `ReadData` is held. Then go to DBG if `dbg_req` is high, otherwise FETCH.
- **DBG:** `dbg_gnt`=1; memory signals driven from the `dbg_*` inputs. When `mem_ready` is high: pulse `dbg_done`, latch `dbg_rdata` (reads only), go to FETCH.
  - At most one debug transaction per instruction boundary, so the core cannot starve.
- **Request rules:** address, write enable and write data stay stable while `mem_req` is high and `mem_ready` is low. `mem_req` is never high in EXEC, COMMIT or HALT.
- **Timeout:** a wait counter clears on entry to each request state and increments each cycle `mem_req`=1 and `mem_ready`=0.
  - Reaching `TIMEOUT`: set `bus_err`, go to HALT. No further requests and no `core_en` until reset.
  - A pending `dbg_done` is not issued.
- **instret:** increments on each `core_en` pulse; wraps 0xFFFFFFFF→0.
- **Reset (async, any state):**
  - State → FETCH.
  - `instruccion`=32'h00000013 (NOP).
  - `ReadData`, `dbg_rdata`, `instret`, wait counter → 0.
  - `bus_err`, `core_en`, `dbg_done`, `dbg_gnt`, `mem_req`, `mem_we` → 0.
  - A transaction in flight is abandoned. The first request is issued in the first cycle after reset deasserts.

## Timing
- `mem_ready` may be combinational in the request cycle; it is sampled at the rising edge.
- Zero-wait memory:
  - Non-memory instruction: 2 cycles (FETCH, EXEC).
  - Load/store: 4 cycles (FETCH, EXEC, DATA, COMMIT).
  - Debug transaction: +1 cycle.
- Each wait cycle adds exactly 1 cycle to the phase it stalls.
- `core_en` is high for exactly one cycle per instruction and never in consecutive cycles.
- `dbg_req` is sampled only in the cycle `core_en` is high.
- When `dbg_req` and the next fetch are both pending, debug wins once; the fetch follows immediately after `dbg_done`.
- Timeout: `bus_err` rises at the edge ending the `TIMEOUT`-th non-ready cycle.

## Test plan
- **Reset and ADDI:** reset pulse, memory returns 32'h00300413 with zero wait.
  - `mem_req` high with `mem_addr`=`pc` in cycle 1.
  - `core_en` pulses in cycle 2; `instret`=1.
- **SW:** fetch 32'h00802023 with x8=3.
  - DATA cycle shows `mem_we`=1, `mem_addr`=0, `mem_wdata`=3.
  - `core_en` in cycle 4.
- **LW with waits:** fetch 32'h00002483 (LW x9,0(x0)), `mem_rdata`=32'hDEADBEEF, 2 wait states in DATA.
  - `ReadData`=32'hDEADBEEF while `core_en` is high in cycle 6.
  - Address held stable during the waits.
- **Debug arbitration:** assert `dbg_req` (read, `dbg_addr`=0x40) mid-fetch.
  - Instruction completes first.
  - `dbg_gnt` is high for one cycle, then `dbg_done` pulses with the latched data.
  - Next cycle: FETCH.
- **Timeout:** `mem_ready` held low.
  - `bus_err`=1 after 16 cycles.
  - `mem_req`=0 thereafter; reset clears `bus_err`.
- **Reset mid-DATA:** assert reset during DATA.
  - All outputs return to reset values immediately.
  - `instret` is unchanged from 0 after the first instruction restarts.
